pc_stack_unit: RTL

- Program-counter stage of the single-cycle CPU; sits directly upstream of the program memory and drives its fetch address.
- Holds the PC and selects its next value from increment or jump target, as steered by the control unit's s_inc.
- Adds a hardware return-address stack for subroutine call/return.
- Reports stack overflow and underflow to the control unit as sticky error flags.

---
 rtl/pc_stack_unit_if.sv | 47 ++++
 rtl/pc_stack_unit.sv | 114 +++++++++++
 2 files changed

// File: rtl/pc_stack_unit_if.sv
// ============================================================================
// pc_stack_unit_if
// ----------------------------------------------------------------------------
// Purpose : Bundles the control-side inputs and the fetch/status outputs of
//           the program-counter stage with its return-address stack.
//
// Signal summary:
//   en      : PC update enable (0 = hold everything)
//   s_inc   : 1 = next PC is PC+1, 0 = next PC is dest
//   call    : push PC+1, jump to dest
//   ret     : pop stack top into PC
//   dest    : jump/call target [ADDR_W-1:0]
//   pc      : current fetch address to program memory
//   sp      : number of valid stack entries, 0..DEPTH
//   stk_ovf : sticky overflow flag
//   stk_unf : sticky underflow flag
//
// Modports:
//   master : control unit side (drives controls, observes pc/sp/flags)
//   slave  : pc_stack_unit side
// ============================================================================
interface pc_stack_unit_if #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 8
);
    localparam int SP_W = $clog2(DEPTH) + 1;

    logic              en;
    logic              s_inc;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] dest;
    logic [ADDR_W-1:0] pc;
    logic [SP_W-1:0]   sp;
    logic              stk_ovf;
    logic              stk_unf;

    modport master (
        output en, s_inc, call, ret, dest,
        input  pc, sp, stk_ovf, stk_unf
    );

    modport slave (
        input  en, s_inc, call, ret, dest,
        output pc, sp, stk_ovf, stk_unf
    );
endinterface

// File: rtl/pc_stack_unit.sv
// ============================================================================
// pc_stack_unit
// ----------------------------------------------------------------------------
// Purpose : Program-counter stage of the single-cycle CPU. Holds the PC,
//           selects increment / jump target / return address, and keeps a
//           hardware return-address stack with sticky overflow/underflow
//           flags.
//
// Ports:
//   clk    : system clock, all state updates on rising edge
//   reset  : asynchronous active-low reset
//   bus    : pc_stack_unit_if.slave (en, s_inc, call, ret, dest in;
//            pc, sp, stk_ovf, stk_unf out)
//
// Parameters:
//   ADDR_W  : PC / jump-target width
//   DEPTH   : return-stack entries (power of two, >= 2)
//   RST_VEC : PC value loaded on reset
//
// Build option:
//   PCU_STK_CIRC_EN : when defined the stack is circular; a call at full
//                     depth discards the oldest entry instead of the new one
//                     and stk_ovf is never set.
//
// Control semantics: there is no valid/ready handshake. A request (call, ret,
// s_inc/dest) is consumed on every rising edge where en=1 and ignored when
// en=0; priority is ret > call > s_inc/dest. All outputs are registered, so
// the new fetch address appears one cycle after the controls.
// ============================================================================
module pc_stack_unit #(
    parameter int              ADDR_W  = 10,
    parameter int              DEPTH   = 8,
    parameter logic [ADDR_W-1:0] RST_VEC = '0
) (
    input logic              clk,
    input logic              reset,
    pc_stack_unit_if.slave   bus
);
    localparam int SP_W  = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic [SP_W-1:0]   r_sp;
    logic [ADDR_W-1:0] r_stack [DEPTH];
    logic              r_ovf;
    logic              r_unf;

    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_full;
    logic              w_empty;
    logic [IDX_W-1:0]  w_push_idx;
    logic [IDX_W-1:0]  w_top_idx;

    always_comb begin
        w_pc_inc   = r_pc + ADDR_W'(1);
        w_full     = (r_sp == SP_W'(DEPTH));
        w_empty    = (r_sp == '0);
        // Low bits of sp address the next free slot; when full they wrap to
        // 0, so subtracting one still lands on the top entry (DEPTH-1).
        w_push_idx = r_sp[IDX_W-1:0];
        w_top_idx  = r_sp[IDX_W-1:0] - IDX_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc  <= RST_VEC;
            r_sp  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (bus.en) begin
            if (bus.ret) begin
                // ret wins over a simultaneous call; the call is dropped.
                if (w_empty) begin
                    r_unf <= 1'b1;
                    r_pc  <= w_pc_inc;
                end else begin
                    r_pc <= r_stack[w_top_idx];
                    r_sp <= r_sp - SP_W'(1);
                end
            end else if (bus.call) begin
                // The jump is taken whether or not the push succeeds.
                r_pc <= bus.dest;
                if (!w_full) begin
                    r_stack[w_push_idx] <= w_pc_inc;
                    r_sp                <= r_sp + SP_W'(1);
                end else begin
`ifdef PCU_STK_CIRC_EN
                    // Slide every entry down one slot, dropping the oldest,
                    // and put the new return address on top.
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        r_stack[i] <= r_stack[i+1];
                    end
                    r_stack[DEPTH-1] <= w_pc_inc;
`else
                    r_ovf <= 1'b1;
`endif
                end
            end else if (bus.s_inc) begin
                r_pc <= w_pc_inc;
            end else begin
                r_pc <= bus.dest;
            end
        end
    end

    assign bus.pc      = r_pc;
    assign bus.sp      = r_sp;
    assign bus.stk_ovf = r_ovf;
    assign bus.stk_unf = r_unf;

endmodule
